square_root_stdp: RTL and testbench

- 16-input STDP (spike-timing-dependent plasticity) synapse array with one postsynaptic neuron.
- Records a spike history for every presynaptic input and for the postsynaptic input.
- Visits one synapse per clock in round-robin order, computes the pre/post spike time difference for it, and updates that synapse's 4-bit weight with a saturating lookup.
- Sits between the spike-generation front end and the neuron core; the weight array output feeds the integrators.

---
 rtl/square_root_stdp.sv | 216 +++++++++++++++++++++
 tb/tb_square_root_stdp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_root_stdp.sv
// -----------------------------------------------------------------------------
// square_root_stdp
//   16-input STDP synapse array with a single postsynaptic neuron.
//   Every input (16 presynaptic + 1 postsynaptic) keeps a HIST-bit spike
//   history: bit0 is the newest sample, bit n is the sample of age n.
//   One synapse per clock is visited in round-robin order. For that synapse the
//   age of the most recent spike inside a 4-sample window is found for both the
//   pre and post histories. Their difference (dt = age_pre - age_post) selects a
//   weight change from a small lookup, and the result is saturated to 0..15.
//   The result is committed when write is high and both windows hold a spike.
//
// Ports
//   clock                 system clock, rising edge active
//   reset                 asynchronous active-low reset
//   write                 1 = commit the computed weight update
//   postsynapSR0          postsynaptic spike
//   presynapSR1..16       presynaptic spikes for synapses 1..16
//   time_difference       signed dt of the selected synapse (combinational)
//   mux_synapse           registered presynaptic sample, bit i-1 = presynapSRi
//   postreg               postsynaptic spike history
//   preonereg/pretworeg/prethreereg  spike histories of synapses 1..3
//   weight_new            saturated updated weight (combinational)
//   weight_old            current weight of the selected synapse
//   dataArray             weight array, synapse k+1 at [4k+3:4k]
//   select                round-robin synapse index
//   weight_new2           weight_new delayed one cycle
//   time_difference_new   time_difference delayed one cycle
// -----------------------------------------------------------------------------
module square_root_stdp #(
    parameter logic [3:0] W_INIT = 4'd8,
    parameter int         HIST   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 postsynapSR0,
    input  logic                 presynapSR1,
    input  logic                 presynapSR2,
    input  logic                 presynapSR3,
    input  logic                 presynapSR4,
    input  logic                 presynapSR5,
    input  logic                 presynapSR6,
    input  logic                 presynapSR7,
    input  logic                 presynapSR8,
    input  logic                 presynapSR9,
    input  logic                 presynapSR10,
    input  logic                 presynapSR11,
    input  logic                 presynapSR12,
    input  logic                 presynapSR13,
    input  logic                 presynapSR14,
    input  logic                 presynapSR15,
    input  logic                 presynapSR16,
    output logic signed [2:0]    time_difference,
    output logic [15:0]          mux_synapse,
    output logic [HIST-1:0]      postreg,
    output logic [HIST-1:0]      preonereg,
    output logic [HIST-1:0]      pretworeg,
    output logic [HIST-1:0]      prethreereg,
    output logic [3:0]           weight_new,
    output logic [3:0]           weight_old,
    output logic [63:0]          dataArray,
    output logic [3:0]           select,
    output logic [3:0]           weight_new2,
    output logic signed [2:0]    time_difference_new
);

    // Index of the lowest set bit of a non-empty 4-bit window (age of newest spike).
    function automatic logic [1:0] lowest_set_idx(input logic [3:0] win);
        logic [1:0] idx;
        if (win[0]) begin
            idx = 2'd0;
        end else if (win[1]) begin
            idx = 2'd1;
        end else if (win[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    logic [15:0]      pre_spikes_s;
    logic [HIST-1:0]  pre_hist_q  [16];
    logic [HIST-1:0]  pre_hist_d  [16];
    logic [HIST-1:0]  post_hist_q;
    logic [HIST-1:0]  post_hist_d;
    logic [15:0]      mux_q;
    logic [3:0]       select_q;
    logic [3:0]       select_d;
    logic [3:0]       weights_q   [16];
    logic [3:0]       weights_d   [16];
    logic [3:0]       weight_new2_q;
    logic signed [2:0] td_new_q;

    logic [3:0]       pre_win_s;
    logic [3:0]       post_win_s;
    logic [1:0]       age_pre_s;
    logic [1:0]       age_post_s;
    logic             valid_s;
    logic signed [2:0] dt_s;
    logic [2:0]       dw_s;
    logic [5:0]       sum_s;
    logic [3:0]       weight_old_s;
    logic [3:0]       weight_new_s;

    assign pre_spikes_s = {presynapSR16, presynapSR15, presynapSR14, presynapSR13,
                           presynapSR12, presynapSR11, presynapSR10, presynapSR9,
                           presynapSR8,  presynapSR7,  presynapSR6,  presynapSR5,
                           presynapSR4,  presynapSR3,  presynapSR2,  presynapSR1};

    // Next-state of the spike histories and the round-robin pointer.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            pre_hist_d[k] = {pre_hist_q[k][HIST-2:0], pre_spikes_s[k]};
        end
        post_hist_d = {post_hist_q[HIST-2:0], postsynapSR0};
        select_d    = select_q + 4'd1;
    end

    // Spike-age extraction and signed time difference of the selected synapse.
    always_comb begin
        pre_win_s  = pre_hist_q[select_q][3:0];
        post_win_s = post_hist_q[3:0];
        age_pre_s  = lowest_set_idx(pre_win_s);
        age_post_s = lowest_set_idx(post_win_s);
        valid_s    = (pre_win_s != 4'd0) && (post_win_s != 4'd0);
        if (valid_s) begin
            dt_s = $signed({1'b0, age_pre_s}) - $signed({1'b0, age_post_s});
        end else begin
            dt_s = 3'sd0;
        end
    end

    // STDP lookup: smaller |dt| gives a larger change; sign follows dt.
    always_comb begin
        case (dt_s)
            3'b001:  dw_s = 3'b011;  // +1 -> +3
            3'b010:  dw_s = 3'b010;  // +2 -> +2
            3'b011:  dw_s = 3'b001;  // +3 -> +1
            3'b111:  dw_s = 3'b101;  // -1 -> -3
            3'b110:  dw_s = 3'b110;  // -2 -> -2
            3'b101:  dw_s = 3'b111;  // -3 -> -1
            default: dw_s = 3'b000;
        endcase
    end

    // Saturating add; a 6-bit sum exposes both underflow (bit5) and overflow (>15).
    always_comb begin
        weight_old_s = weights_q[select_q];
        sum_s        = {2'b00, weight_old_s} + {{3{dw_s[2]}}, dw_s};
        if (sum_s[5]) begin
            weight_new_s = 4'd0;
        end else if (sum_s > 6'd15) begin
            weight_new_s = 4'd15;
        end else begin
            weight_new_s = sum_s[3:0];
        end
    end

    // Weight commit for the currently selected synapse.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            weights_d[k] = weights_q[k];
        end
        if (write && valid_s) begin
            weights_d[select_q] = weight_new_s;
        end else begin
            weights_d[select_q] = weights_q[select_q];
        end
    end

    // State registers: histories, pointer, weights and the one-cycle output pipeline.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 16; k++) begin
                pre_hist_q[k] <= '0;
                weights_q[k]  <= W_INIT;
            end
            post_hist_q   <= '0;
            mux_q         <= 16'd0;
            select_q      <= 4'd0;
            weight_new2_q <= 4'd0;
            td_new_q      <= 3'sd0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                pre_hist_q[k] <= pre_hist_d[k];
                weights_q[k]  <= weights_d[k];
            end
            post_hist_q   <= post_hist_d;
            mux_q         <= pre_spikes_s;
            select_q      <= select_d;
            weight_new2_q <= weight_new_s;
            td_new_q      <= dt_s;
        end
    end

    // Flatten the weight array onto the output bus.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            dataArray[4*k +: 4] = weights_q[k];
        end
    end

    assign time_difference     = dt_s;
    assign mux_synapse         = mux_q;
    assign postreg             = post_hist_q;
    assign preonereg           = pre_hist_q[0];
    assign pretworeg           = pre_hist_q[1];
    assign prethreereg         = pre_hist_q[2];
    assign weight_new          = weight_new_s;
    assign weight_old          = weight_old_s;
    assign select              = select_q;
    assign weight_new2         = weight_new2_q;
    assign time_difference_new = td_new_q;

endmodule

// File: tb/tb_square_root_stdp.sv
// -----------------------------------------------------------------------------
// tb_square_root_stdp
//   Scoreboard bench: the stimulus process drives inputs on the falling edge,
//   advances a sample-array reference model by one clock and queues the
//   expected post-edge outputs; a monitor pops and compares after each rising
//   edge.
// -----------------------------------------------------------------------------
module tb_square_root_stdp;

    logic        clock = 1'b0;
    logic        reset;
    logic        write;
    logic        post_spk;
    logic [15:0] pre_spk;

    logic signed [2:0] time_difference;
    logic [15:0]       mux_synapse;
    logic [15:0]       postreg, preonereg, pretworeg, prethreereg;
    logic [3:0]        weight_new, weight_old, select, weight_new2;
    logic [63:0]       dataArray;
    logic signed [2:0] time_difference_new;

    always #5 clock = ~clock;

    square_root_stdp #(.W_INIT(4'd8), .HIST(16)) dut (
        .clock(clock), .reset(reset), .write(write), .postsynapSR0(post_spk),
        .presynapSR1(pre_spk[0]),   .presynapSR2(pre_spk[1]),
        .presynapSR3(pre_spk[2]),   .presynapSR4(pre_spk[3]),
        .presynapSR5(pre_spk[4]),   .presynapSR6(pre_spk[5]),
        .presynapSR7(pre_spk[6]),   .presynapSR8(pre_spk[7]),
        .presynapSR9(pre_spk[8]),   .presynapSR10(pre_spk[9]),
        .presynapSR11(pre_spk[10]), .presynapSR12(pre_spk[11]),
        .presynapSR13(pre_spk[12]), .presynapSR14(pre_spk[13]),
        .presynapSR15(pre_spk[14]), .presynapSR16(pre_spk[15]),
        .time_difference(time_difference), .mux_synapse(mux_synapse),
        .postreg(postreg), .preonereg(preonereg), .pretworeg(pretworeg),
        .prethreereg(prethreereg), .weight_new(weight_new), .weight_old(weight_old),
        .dataArray(dataArray), .select(select), .weight_new2(weight_new2),
        .time_difference_new(time_difference_new)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [63:0] data;
        logic [2:0]  td;
        logic [3:0]  wn;
        logic [3:0]  wold;
        logic [3:0]  wn2;
        logic [2:0]  tdn;
        logic [15:0] post;
        logic [15:0] pre1;
        logic [15:0] pre2;
        logic [15:0] pre3;
        logic [15:0] mux;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: sample arrays indexed by age (0 = newest).
    int m_post[16];
    int m_pre[16][16];
    int m_mux[16];
    int m_w[16];
    int m_sel;
    int m_wn2;
    int m_tdn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic int newest_post();
        for (int k = 0; k < 4; k++) if (m_post[k] != 0) return k;
        return -1;
    endfunction

    function automatic int newest_pre(input int s);
        for (int k = 0; k < 4; k++) if (m_pre[s][k] != 0) return k;
        return -1;
    endfunction

    // dt, candidate weight and validity for the currently selected synapse.
    task automatic eval(output int td, output int wn, output bit vld);
        int ap, aq, dw;
        ap  = newest_pre(m_sel);
        aq  = newest_post();
        vld = (ap >= 0) && (aq >= 0);
        td  = vld ? ap - aq : 0;
        if (td > 0)      dw = 4 - td;
        else if (td < 0) dw = -(4 + td);
        else             dw = 0;
        wn = m_w[m_sel] + dw;
        if (wn < 0)  wn = 0;
        if (wn > 15) wn = 15;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_post[s] = 0;
            m_mux[s]  = 0;
            m_w[s]    = 8;
            for (int a = 0; a < 16; a++) m_pre[s][a] = 0;
        end
        m_sel = 0; m_wn2 = 0; m_tdn = 0;
    endtask

    task automatic model_step(input bit wr, input bit post, input logic [15:0] pre);
        int td, wn;
        bit vld;
        eval(td, wn, vld);
        if (wr && vld) m_w[m_sel] = wn;
        m_wn2 = wn;
        m_tdn = td;
        for (int a = 15; a > 0; a--) begin
            m_post[a] = m_post[a-1];
            for (int s = 0; s < 16; s++) m_pre[s][a] = m_pre[s][a-1];
        end
        m_post[0] = post;
        for (int s = 0; s < 16; s++) begin
            m_pre[s][0] = pre[s];
            m_mux[s]    = pre[s];
        end
        m_sel = (m_sel + 1) % 16;
    endtask

    function automatic logic [15:0] hist_bits(input int s);
        logic [15:0] v;
        for (int a = 0; a < 16; a++) v[a] = (m_pre[s][a] != 0);
        return v;
    endfunction

    task automatic push_expected();
        exp_t e;
        int td, wn;
        bit vld;
        eval(td, wn, vld);
        e.sel  = 4'(m_sel);
        e.td   = 3'(td);
        e.wn   = 4'(wn);
        e.wold = 4'(m_w[m_sel]);
        e.wn2  = 4'(m_wn2);
        e.tdn  = 3'(m_tdn);
        for (int s = 0; s < 16; s++) begin
            e.data[4*s +: 4] = 4'(m_w[s]);
            e.post[s]        = (m_post[s] != 0);
            e.mux[s]         = (m_mux[s] != 0);
        end
        e.pre1 = hist_bits(0);
        e.pre2 = hist_bits(1);
        e.pre3 = hist_bits(2);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit wr, input bit post, input logic [15:0] pre);
        write    = wr;
        post_spk = post;
        pre_spk  = pre;
        model_step(wr, post, pre);
        push_expected();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data"},   dataArray, 64'h8888_8888_8888_8888);
        chk({tag, "_select"}, {60'd0, select}, 64'd0);
        chk({tag, "_post"},   {48'd0, postreg}, 64'd0);
        chk({tag, "_pre1"},   {48'd0, preonereg}, 64'd0);
        chk({tag, "_pre2"},   {48'd0, pretworeg}, 64'd0);
        chk({tag, "_pre3"},   {48'd0, prethreereg}, 64'd0);
        chk({tag, "_mux"},    {48'd0, mux_synapse}, 64'd0);
        chk({tag, "_wn2"},    {60'd0, weight_new2}, 64'd0);
        chk({tag, "_tdn"},    {61'd0, $unsigned(time_difference_new)}, 64'd0);
        chk({tag, "_td"},     {61'd0, $unsigned(time_difference)}, 64'd0);
        chk({tag, "_wn"},     {60'd0, weight_new}, 64'd8);
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("select",   {60'd0, select},      {60'd0, mon_e.sel});
            chk("data",     dataArray,            mon_e.data);
            chk("td",       {61'd0, $unsigned(time_difference)}, {61'd0, mon_e.td});
            chk("wnew",     {60'd0, weight_new},  {60'd0, mon_e.wn});
            chk("wold",     {60'd0, weight_old},  {60'd0, mon_e.wold});
            chk("wnew2",    {60'd0, weight_new2}, {60'd0, mon_e.wn2});
            chk("td_new",   {61'd0, $unsigned(time_difference_new)}, {61'd0, mon_e.tdn});
            chk("postreg",  {48'd0, postreg},     {48'd0, mon_e.post});
            chk("pre1reg",  {48'd0, preonereg},   {48'd0, mon_e.pre1});
            chk("pre2reg",  {48'd0, pretworeg},   {48'd0, mon_e.pre2});
            chk("pre3reg",  {48'd0, prethreereg}, {48'd0, mon_e.pre3});
            chk("mux",      {48'd0, mux_synapse}, {48'd0, mon_e.mux});
        end
    end

    initial begin
        logic [15:0] rnd;
        reset    = 1'b0;
        write    = 1'b0;
        post_spk = 1'b0;
        pre_spk  = 16'd0;
        repeat (3) @(negedge clock);
        check_reset_state("reset");
        model_reset();
        reset = 1'b1;

        // Pre one cycle before post, period 4: each synapse sees a fixed phase,
        // so some saturate high (repeated +3) and others low.
        for (int i = 0; i < 96; i++) begin
            drive(1'b1, (i % 4) == 1, ((i % 4) == 0) ? 16'hFFFF : 16'h0000);
            @(negedge clock);
        end

        // Post one cycle before pre: depression-dominated phases.
        for (int i = 0; i < 96; i++) begin
            drive(1'b1, (i % 4) == 0, ((i % 4) == 1) ? 16'hFFFF : 16'h0000);
            @(negedge clock);
        end

        // Random sparse spikes with random write enable.
        for (int i = 0; i < 160; i++) begin
            for (int b = 0; b < 16; b++) rnd[b] = ($urandom_range(0, 2) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rnd);
            @(negedge clock);
        end

        // Weights frozen while histories keep moving.
        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 16; b++) rnd[b] = ($urandom_range(0, 1) == 0);
            drive(1'b0, $urandom_range(0, 1) == 0, rnd);
            @(negedge clock);
        end

        // Long gaps without post spikes: dt must stay 0 outside the window.
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, (i % 8) == 0, 16'hFFFF);
            @(negedge clock);
        end

        write    = 1'b0;
        post_spk = 1'b0;
        pre_spk  = 16'd0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        // Asynchronous reset in the middle of a cycle with spikes and write active.
        write    = 1'b1;
        post_spk = 1'b1;
        pre_spk  = 16'hFFFF;
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge clock);
        check_reset_state("held_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
